regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
- Sequences all accesses to the 32x32 register file, which has no reset, a synchronous write port and two registered read ports.
- After reset it zero-fills every register, then shares the single write port between the ALU writeback and load writeback requesters.
- Issues decode read requests and returns read data one cycle later with a valid flag.
- Sits between decode/writeback stages and the register file.

Parameters:
- XLEN, 32, data width of registers and all data ports.
- STARVE_LIMIT, 4, consecutive lost arbitration cycles after which the ALU source gets priority (range 1..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- alu_wb_valid  in  1  ALU writeback request
- alu_wb_rd  in  5  ALU destination register
- alu_wb_data  in  XLEN  ALU writeback data
- alu_wb_ready  out  1  ALU request accepted this cycle
- mem_wb_valid  in  1  load writeback request
- mem_wb_rd  in  5  load destination register
- mem_wb_data  in  XLEN  load writeback data
- mem_wb_ready  out  1  load request accepted this cycle
- rd_req_valid  in  1  operand read request
- rd_req_rs1  in  5  first source register
- rd_req_rs2  in  5  second source register
- rd_req_ready  out  1  read accepted
- rd_rsp_valid  out  1  operand data valid
- rd_rsp_data1  out  XLEN  rs1 contents
- rd_rsp_data2  out  XLEN  rs2 contents
- init_done  out  1  zero-fill complete
- rf_addr1  out  5  to register file rs1 address
- rf_addr2  out  5  to register file rs2 address
- rf_addr3  out  5  to register file rd address
- rf_regwrite  out  1  to register file write enable
- rf_datain  out  XLEN  to register file write data
- rf_rdata1  in  XLEN  from register file read line 1
- rf_rdata2  in  XLEN  from register file read line 2

Behaviour:
- States: INIT, RUN.
  - Reset (asynchronous, any time, including mid-init or mid-write) forces INIT with init counter = 0.
  - Outputs during reset: init_done=0, all ready=0, rd_rsp_valid=0, rf_regwrite=0, rd_rsp_data1/2=0, starvation counter=0.
- INIT:
  - rf_regwrite=1, rf_addr3=counter, rf_datain=0.
  - Counter increments each cycle; after writing address 31, go to RUN (32 cycles total).
  - init_done=1 from the first RUN cycle; all ready outputs stay 0 throughout INIT.
- RUN, write arbitration (combinational grant each cycle):
  - Only one valid: it is granted.
  - Both valid: mem wins, unless the starvation counter >= STARVE_LIMIT, in which case alu wins.
  - Starvation counter increments (saturating at 15) when alu is valid and loses; clears when alu is granted or alu_wb_valid=0.
  - The granted source's ready=1 in the same cycle. Handshake completes when valid&ready; the requester holds its inputs until then.
  - Granted write drives rf_addr3/rf_datain, and rf_regwrite=1 unless rd==0. Writes to x0 are acknowledged but suppressed.
- RUN, reads:
  - rd_req_ready=1 whenever in RUN; rf_addr1/2 = rd_req_rs1/rs2.
  - An accepted read sets rd_rsp_valid=1 in the next cycle only. Data is rf_rdata1/2, forced to 0 when the corresponding rs was 0 (addresses registered at accept).
  - Back-to-back reads every cycle are allowed.
- Same-cycle read and write to the same nonzero address: rd_rsp returns the old value (no forwarding) unless RF_BYPASS_EN is defined.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: when an accepted read and a granted nonzero write hit the same address in the same cycle, rd_rsp_data for that operand returns the new write data. This requires a registered match flag and write-data hold register per operand.
- Undefined: old value returned, no extra registers.

Test Plan:
- Deassert reset_n, run 32 cycles -> rf_regwrite=1 with addresses 0..31 and data 0; init_done=1 on cycle 33; reading x5 returns 0.
- RUN: both valid, mem rd=3 0xAAAA_0000 and alu rd=4 0x1234 held, STARVE_LIMIT=4 -> mem granted first; alu granted on the 2nd cycle once mem drops; x3=0xAAAA_0000, x4=0x1234.
- mem_wb_valid held high with new rd each cycle plus alu pending -> alu loses 4 cycles, alu_wb_ready=1 on cycle 5, counter cleared.
- alu write rd=0 data 0xFFFF_FFFF -> alu_wb_ready=1, rf_regwrite=0; a later read of x0 returns 0.
- Write x7=0x55, then same-cycle read x7 with write x7=0x99 -> rsp 0x55 without RF_BYPASS_EN, 0x99 with it; the next read returns 0x99.
- Assert reset_n low during INIT at count 17 -> returns to INIT at 0; a full 32-cycle sweep repeats before init_done.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: sequences every access to a 32x32 register file that
// has no reset, one synchronous write port and two registered read ports.
// After reset the block zero-fills all 32 registers, then arbitrates the
// single write port between ALU and load writeback and serves operand reads
// with a one-cycle response.
// Optional build macro RF_BYPASS_EN: a read accepted in the same cycle as a
// granted nonzero write to the same register returns the new write data.
module regfile_access_ctrl #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            alu_wb_valid,
  input  logic [4:0]      alu_wb_rd,
  input  logic [XLEN-1:0] alu_wb_data,
  output logic            alu_wb_ready,
  input  logic            mem_wb_valid,
  input  logic [4:0]      mem_wb_rd,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic            mem_wb_ready,
  input  logic            rd_req_valid,
  input  logic [4:0]      rd_req_rs1,
  input  logic [4:0]      rd_req_rs2,
  output logic            rd_req_ready,
  output logic            rd_rsp_valid,
  output logic [XLEN-1:0] rd_rsp_data1,
  output logic [XLEN-1:0] rd_rsp_data2,
  output logic            init_done,
  output logic [4:0]      rf_addr1,
  output logic [4:0]      rf_addr2,
  output logic [4:0]      rf_addr3,
  output logic            rf_regwrite,
  output logic [XLEN-1:0] rf_datain,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2
);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);

  state_t          state_r;
  logic [4:0]      init_cnt_r;
  logic [3:0]      starve_cnt_r;
  logic            rsp_valid_r;
  logic            rs1_zero_r;
  logic            rs2_zero_r;

  logic            run_s;
  logic            alu_grant_s;
  logic            mem_grant_s;
  logic            rd_accept_s;
  logic            wr_en_s;
  logic [4:0]      wr_addr_s;
  logic [XLEN-1:0] wr_data_s;
  logic [XLEN-1:0] src1_s;
  logic [XLEN-1:0] src2_s;

  // Write-port arbitration: mem wins ties unless the ALU has starved too long.
  always_comb begin
    run_s       = (state_r == ST_RUN);
    rd_accept_s = run_s & rd_req_valid;
    alu_grant_s = 1'b0;
    mem_grant_s = 1'b0;
    if (run_s) begin
      if (alu_wb_valid && (!mem_wb_valid || (starve_cnt_r >= STARVE_LIM_C))) begin
        alu_grant_s = 1'b1;
      end else if (mem_wb_valid) begin
        mem_grant_s = 1'b1;
      end else begin
        mem_grant_s = 1'b0;
      end
    end else begin
      alu_grant_s = 1'b0;
    end
  end

  // Write-port mux: zero-fill sweep in INIT, granted writeback in RUN.
  // The INIT enable is qualified by reset_n so nothing is written while reset is held.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = 5'd0;
    wr_data_s = '0;
    if (!run_s) begin
      wr_en_s   = reset_n;
      wr_addr_s = init_cnt_r;
    end else if (alu_grant_s) begin
      wr_en_s   = (alu_wb_rd != 5'd0);
      wr_addr_s = alu_wb_rd;
      wr_data_s = alu_wb_data;
    end else if (mem_grant_s) begin
      wr_en_s   = (mem_wb_rd != 5'd0);
      wr_addr_s = mem_wb_rd;
      wr_data_s = mem_wb_data;
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // INIT/RUN sequencing with the zero-fill address counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_INIT;
      init_cnt_r <= 5'd0;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_cnt_r <= init_cnt_r + 5'd1;
          if (init_cnt_r == 5'd31) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
        end
        default: begin
          state_r    <= ST_INIT;
          init_cnt_r <= 5'd0;
        end
      endcase
    end
  end

  // Starvation counter: counts consecutive ALU losses, saturating at 15.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_r <= 4'd0;
    end else if (run_s && alu_wb_valid && !alu_grant_s) begin
      if (starve_cnt_r != 4'd15) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end
    end else begin
      starve_cnt_r <= 4'd0;
    end
  end

  // Read response tracking: one-cycle valid plus x0 flags captured at accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_r <= 1'b0;
      rs1_zero_r  <= 1'b0;
      rs2_zero_r  <= 1'b0;
    end else begin
      rsp_valid_r <= rd_accept_s;
      if (rd_accept_s) begin
        rs1_zero_r <= (rd_req_rs1 == 5'd0);
        rs2_zero_r <= (rd_req_rs2 == 5'd0);
      end
    end
  end

`ifdef RF_BYPASS_EN
  logic            byp1_r;
  logic            byp2_r;
  logic [XLEN-1:0] byp_data1_r;
  logic [XLEN-1:0] byp_data2_r;

  // Same-cycle read/write collision capture for forwarding the new data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byp1_r      <= 1'b0;
      byp2_r      <= 1'b0;
      byp_data1_r <= '0;
      byp_data2_r <= '0;
    end else begin
      byp1_r      <= rd_accept_s & wr_en_s & (rd_req_rs1 == wr_addr_s);
      byp2_r      <= rd_accept_s & wr_en_s & (rd_req_rs2 == wr_addr_s);
      byp_data1_r <= wr_data_s;
      byp_data2_r <= wr_data_s;
    end
  end

  assign src1_s = byp1_r ? byp_data1_r : rf_rdata1;
  assign src2_s = byp2_r ? byp_data2_r : rf_rdata2;
`else
  assign src1_s = rf_rdata1;
  assign src2_s = rf_rdata2;
`endif

  assign alu_wb_ready = alu_grant_s;
  assign mem_wb_ready = mem_grant_s;
  assign rd_req_ready = run_s;
  assign init_done    = run_s;
  assign rf_addr1     = rd_req_rs1;
  assign rf_addr2     = rd_req_rs2;
  assign rf_addr3     = wr_addr_s;
  assign rf_regwrite  = wr_en_s;
  assign rf_datain    = wr_data_s;
  assign rd_rsp_valid = rsp_valid_r;
  assign rd_rsp_data1 = (rsp_valid_r && !rs1_zero_r) ? src1_s : '0;
  assign rd_rsp_data2 = (rsp_valid_r && !rs2_zero_r) ? src2_s : '0;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl with a behavioural register
// file (no reset, registered reads) and a read-response scoreboard.
module tb_regfile_access_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            alu_wb_valid;
  logic [4:0]      alu_wb_rd;
  logic [XLEN-1:0] alu_wb_data;
  logic            alu_wb_ready;
  logic            mem_wb_valid;
  logic [4:0]      mem_wb_rd;
  logic [XLEN-1:0] mem_wb_data;
  logic            mem_wb_ready;
  logic            rd_req_valid;
  logic [4:0]      rd_req_rs1;
  logic [4:0]      rd_req_rs2;
  logic            rd_req_ready;
  logic            rd_rsp_valid;
  logic [XLEN-1:0] rd_rsp_data1;
  logic [XLEN-1:0] rd_rsp_data2;
  logic            init_done;
  logic [4:0]      rf_addr1;
  logic [4:0]      rf_addr2;
  logic [4:0]      rf_addr3;
  logic            rf_regwrite;
  logic [XLEN-1:0] rf_datain;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;

  logic [XLEN-1:0] rf_mem [32];
  logic [XLEN-1:0] exp_rf [32];
  logic [63:0]     sb_q [$];
  logic [63:0]     sb_e;
  int              errors = 0;
  int              checks = 0;

  regfile_access_ctrl #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_wb_ready),
    .rd_req_valid(rd_req_valid), .rd_req_rs1(rd_req_rs1), .rd_req_rs2(rd_req_rs2),
    .rd_req_ready(rd_req_ready),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data1(rd_rsp_data1), .rd_rsp_data2(rd_rsp_data2),
    .init_done(init_done),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_addr3(rf_addr3),
    .rf_regwrite(rf_regwrite), .rf_datain(rf_datain),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
  );

  always #5 clk = ~clk;

  // Register file power-up garbage, so a missing zero-fill is visible.
  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hDEAD_0000 | 32'(i);
  end

  // Behavioural register file: synchronous write, registered reads.
  always @(posedge clk) begin
    if (rf_regwrite) rf_mem[rf_addr3] <= rf_datain;
    rf_rdata1 <= rf_mem[rf_addr1];
    rf_rdata2 <= rf_mem[rf_addr2];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rd_rsp_valid) begin
      if (sb_q.size() == 0) begin
        check_val("rsp_unexpected", 32'(rd_rsp_valid), 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check_val("rsp_data1", rd_rsp_data1, sb_e[63:32]);
        check_val("rsp_data2", rd_rsp_data2, sb_e[31:0]);
      end
    end
  end

  function automatic logic [31:0] exp_of(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : exp_rf[a];
  endfunction

  // Called at a negedge; the read is accepted at the following posedge.
  task automatic issue_read(input logic [4:0] a, input logic [4:0] b,
                            input logic [31:0] e1, input logic [31:0] e2);
    rd_req_valid = 1'b1;
    rd_req_rs1   = a;
    rd_req_rs2   = b;
    sb_q.push_back({e1, e2});
    #1;
    check_val("rd_req_ready", 32'(rd_req_ready), 32'd1);
    @(negedge clk);
    rd_req_valid = 1'b0;
  endtask

  // Called at the negedge where reset is released; returns in the first RUN cycle.
  task automatic init_sweep();
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd9; alu_wb_data = 32'h1111_1111;
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd9; mem_wb_data = 32'h2222_2222;
    rd_req_valid = 1'b1; rd_req_rs1 = 5'd5; rd_req_rs2 = 5'd6;
    for (int i = 0; i < 32; i++) begin
      #1;
      check_val("init_addr", 32'(rf_addr3), 32'(i));
      check_val("init_we", 32'(rf_regwrite), 32'd1);
      check_val("init_data", rf_datain, 32'd0);
      check_val("init_done_lo", 32'(init_done), 32'd0);
      check_val("init_readies", 32'({alu_wb_ready, mem_wb_ready, rd_req_ready}), 32'd0);
      @(negedge clk);
    end
    alu_wb_valid = 1'b0; mem_wb_valid = 1'b0; rd_req_valid = 1'b0;
    #1;
    check_val("init_done_hi", 32'(init_done), 32'd1);
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd1; alu_wb_data = 32'h0;
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd2; mem_wb_data = 32'h0;
    rd_req_valid = 1'b1; rd_req_rs1 = 5'd1; rd_req_rs2 = 5'd2;
    repeat (3) @(negedge clk);
    check_val("rst_init_done", 32'(init_done), 32'd0);
    check_val("rst_we", 32'(rf_regwrite), 32'd0);
    check_val("rst_readies", 32'({alu_wb_ready, mem_wb_ready, rd_req_ready}), 32'd0);
    check_val("rst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    check_val("rst_rsp_data", rd_rsp_data1 | rd_rsp_data2, 32'd0);
    alu_wb_valid = 1'b0; mem_wb_valid = 1'b0; rd_req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    init_sweep();

    // zero-filled registers read back as zero
    issue_read(5'd5, 5'd31, 32'd0, 32'd0);

    // both valid: mem first, then alu once mem drops
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd3; mem_wb_data = 32'hAAAA_0000;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd4; alu_wb_data = 32'h0000_1234;
    #1;
    check_val("arb_mem_rdy", 32'(mem_wb_ready), 32'd1);
    check_val("arb_alu_rdy0", 32'(alu_wb_ready), 32'd0);
    check_val("arb_we_addr", 32'({rf_regwrite, rf_addr3}), 32'h23);
    exp_rf[3] = mem_wb_data;
    @(negedge clk);
    mem_wb_valid = 1'b0;
    #1;
    check_val("arb_alu_rdy1", 32'(alu_wb_ready), 32'd1);
    check_val("arb_alu_data", rf_datain, 32'h0000_1234);
    exp_rf[4] = alu_wb_data;
    @(negedge clk);
    alu_wb_valid = 1'b0;
    issue_read(5'd3, 5'd4, exp_of(5'd3), exp_of(5'd4));

    // starvation: alu loses four cycles, wins on the fifth
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd20; alu_wb_data = 32'hA1A1_0020;
    mem_wb_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_wb_rd   = 5'(21 + i);
      mem_wb_data = 32'hB0B0_0000 + 32'(i);
      #1;
      check_val("starve_alu_rdy", 32'(alu_wb_ready), 32'(i == 4));
      check_val("starve_mem_rdy", 32'(mem_wb_ready), 32'(i != 4));
      if (i == 4) exp_rf[20] = alu_wb_data;
      else exp_rf[21 + i] = mem_wb_data;
      @(negedge clk);
    end
    // counter cleared on grant: mem wins again against a new alu request
    alu_wb_rd = 5'd26; alu_wb_data = 32'hC0C0_0026;
    #1;
    check_val("starve_clr_mem", 32'(mem_wb_ready), 32'd1);
    check_val("starve_clr_alu", 32'(alu_wb_ready), 32'd0);
    exp_rf[25] = mem_wb_data;
    @(negedge clk);
    mem_wb_valid = 1'b0;
    #1;
    check_val("alu_alone_rdy", 32'(alu_wb_ready), 32'd1);
    exp_rf[26] = alu_wb_data;
    @(negedge clk);
    alu_wb_valid = 1'b0;
    issue_read(5'd20, 5'd21, exp_of(5'd20), exp_of(5'd21));
    issue_read(5'd24, 5'd25, exp_of(5'd24), exp_of(5'd25));
    issue_read(5'd26, 5'd22, exp_of(5'd26), exp_of(5'd22));

    // write to x0 is acknowledged but suppressed
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'hFFFF_FFFF;
    #1;
    check_val("x0_rdy", 32'(alu_wb_ready), 32'd1);
    check_val("x0_we", 32'(rf_regwrite), 32'd0);
    @(negedge clk);
    alu_wb_valid = 1'b0;
    issue_read(5'd0, 5'd4, 32'd0, exp_of(5'd4));

    // same-cycle read and write of x7
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd7; mem_wb_data = 32'h0000_0055;
    #1;
    check_val("x7_mem_rdy", 32'(mem_wb_ready), 32'd1);
    exp_rf[7] = mem_wb_data;
    @(negedge clk);
    mem_wb_valid = 1'b0;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd7; alu_wb_data = 32'h0000_0099;
    #1;
    check_val("x7_alu_rdy", 32'(alu_wb_ready), 32'd1);
`ifdef RF_BYPASS_EN
    issue_read(5'd7, 5'd7, 32'h0000_0099, 32'h0000_0099);
`else
    issue_read(5'd7, 5'd7, 32'h0000_0055, 32'h0000_0055);
`endif
    alu_wb_valid = 1'b0;
    exp_rf[7] = 32'h0000_0099;
    issue_read(5'd7, 5'd3, exp_of(5'd7), exp_of(5'd3));

    // back-to-back reads every cycle
    for (int i = 0; i < 4; i++) begin
      issue_read(5'(20 + i), 5'(3 + i), exp_of(5'(20 + i)), exp_of(5'(3 + i)));
    end
    repeat (3) @(negedge clk);

    // reset in the middle of the zero-fill restarts the sweep from 0
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (17) @(negedge clk);
    #1;
    check_val("mid_init_addr", 32'(rf_addr3), 32'd17);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_we", 32'(rf_regwrite), 32'd0);
    check_val("mid_rst_done", 32'(init_done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    init_sweep();
    issue_read(5'd20, 5'd25, 32'd0, 32'd0);
    issue_read(5'd7, 5'd4, 32'd0, 32'd0);

    repeat (3) @(negedge clk);
    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
